// File: rtl/flash_pkg.sv
// flash_pkg: encodings, state/primitive types and the per-command bus sequence table for flash_ctrl
package flash_pkg;
   typedef enum logic [1:0] {OP_READ = 2'd0, OP_PROG = 2'd1, OP_ERASE = 2'd2, OP_STATUS = 2'd3} op_cmd_e;
   localparam logic [7:0] FC_PROG    = 8'h40;
   localparam logic [7:0] FC_ERASE   = 8'h20;
   localparam logic [7:0] FC_CONFIRM = 8'hD0;
   localparam logic [7:0] FC_RDSR    = 8'h70;
   localparam logic [7:0] FC_CLRSR   = 8'h50;
   localparam logic [7:0] FC_RDARR   = 8'hFF;
   localparam int SR_BLS  = 1;
   localparam int SR_VPPS = 3;
   localparam int SR_PS   = 4;
   localparam int SR_ES   = 5;
   localparam int SR_WSMS = 7;
   typedef enum logic [3:0] {INIT, IDLE, W_SETUP, W_STROBE, W_HOLD, R_STROBE, R_RECOV, STS_WAIT, RESP} state_e;
   typedef enum logic [1:0] {P_WR, P_RD, P_WAIT, P_END} prim_e;
   typedef struct packed {
      prim_e      kind;
      logic [7:0] cb;
      logic       use_wd;
   } prim_t;
   // Step of the closing read-array write in PROGRAM/ERASE; reused by INIT and by the STS timeout.
   localparam logic [2:0] STEP_RDARR = 3'd6;
   function automatic prim_t seq_prim(input op_cmd_e cmd, input logic [2:0] step);
      prim_t p;
      p = '{P_END, 8'h00, 1'b0};
      case (cmd)
         OP_READ: if (step == 3'd0) p.kind = P_RD;
         OP_STATUS:
            case (step)
               3'd0: p = '{P_WR, FC_RDSR, 1'b0};
               3'd1: p.kind = P_RD;
               3'd2: p = '{P_WR, FC_RDARR, 1'b0};
               default: ;
            endcase
         default:
            case (step)
               3'd0: p = '{P_WR, (cmd == OP_PROG) ? FC_PROG : FC_ERASE, 1'b0};
               3'd1: p = '{P_WR, FC_CONFIRM, cmd == OP_PROG};
               3'd2: p.kind = P_WAIT;
               3'd3: p = '{P_WR, FC_RDSR, 1'b0};
               3'd4: p.kind = P_RD;
               3'd5: p = '{P_WR, FC_CLRSR, 1'b0};
               3'd6: p = '{P_WR, FC_RDARR, 1'b0};
               default: ;
            endcase
      endcase
      return p;
   endfunction
endpackage

// File: rtl/flash_wait_counter.sv
// flash_wait_counter: loadable down-counter, done while the count is zero
// Ports: CLK_50MHZ/RST clock and sync reset; load/load_val preset; done when expired.
module flash_wait_counter #(
   parameter int W = 24
) (
   input  logic         CLK_50MHZ,
   input  logic         RST,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);
   logic [W-1:0] cnt;
   always_ff @(posedge CLK_50MHZ) begin
      if (RST) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (cnt != '0) cnt <= cnt - 1'b1;
   end
   assign done = (cnt == '0);
endmodule

// File: rtl/flash_ctrl.sv
// flash_ctrl: single-operation controller for parallel NOR flash (Intel command set)
// Ports: op_* request (valid/ready), rsp_* one-cycle response, NF_* registered flash pins
// (NF_D_O/NF_D_OE/NF_D_I feed the top-level tristate), NF_STS ready/busy input.
module flash_ctrl
   import flash_pkg::*;
#(
   parameter int ADDR_W = 24,
   parameter int DATA_W = 8,
   parameter int T_ACC  = 6,
   parameter int T_WP   = 4,
   parameter int T_TMO  = (1 << 24) - 1
) (
   input  logic              CLK_50MHZ,
   input  logic              RST,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [1:0]        op_cmd,
   input  logic [ADDR_W-1:0] op_addr,
   input  logic [DATA_W-1:0] op_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] NF_A,
   output logic [DATA_W-1:0] NF_D_O,
   output logic              NF_D_OE,
   input  logic [DATA_W-1:0] NF_D_I,
   output logic              NF_CE,
   output logic              NF_OE,
   output logic              NF_WE,
   output logic              NF_RP,
   output logic              NF_BYTE,
   output logic              NF_WP,
   input  logic              NF_STS
);
   localparam int CW = $clog2(T_TMO + 1);
   state_e            state, nxt;
   op_cmd_e           cmd_r, sel_cmd;
   logic [2:0]        step_r, idx;
   logic              init_r, err_r, go, tmo, accept, sts_q1, sts_q2;
   logic              cnt_load, cnt_done;
   logic [CW-1:0]     cnt_val;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wd_r, data_r, sel_wd;
   prim_t             prim;
   assign NF_RP   = 1'b1;
   assign NF_WP   = 1'b0;
   assign NF_BYTE = (DATA_W == 16);
   assign accept  = (state == IDLE) && op_valid;
   assign sel_wd  = (state == IDLE) ? op_wdata : wd_r;
   // go: the current primitive has finished, launch the one selected by idx.
   // R_RECOV doubles as the CE-high gap after every read or write primitive.
   always_comb begin
      nxt     = state;
      go      = 1'b0;
      tmo     = 1'b0;
      sel_cmd = cmd_r;
      idx     = step_r;
      case (state)
         INIT: begin
            go      = 1'b1;
            sel_cmd = OP_PROG;
            idx     = STEP_RDARR;
         end
         IDLE: begin
            go      = op_valid;
            sel_cmd = op_cmd_e'(op_cmd);
            idx     = 3'd0;
         end
         W_SETUP:  nxt = W_STROBE;
         W_STROBE: nxt = cnt_done ? W_HOLD : W_STROBE;
         W_HOLD:   nxt = R_RECOV;
         R_STROBE: nxt = cnt_done ? R_RECOV : R_STROBE;
         R_RECOV:  go = 1'b1;
         STS_WAIT: begin
            go  = sts_q2 | cnt_done;
            tmo = !sts_q2 && cnt_done;
            idx = tmo ? STEP_RDARR : step_r;
         end
         RESP:     nxt = IDLE;
         default:  nxt = INIT;
      endcase
      prim = seq_prim(sel_cmd, idx);
      if (go)
         nxt = (prim.kind == P_WR) ? W_SETUP :
               (prim.kind == P_RD) ? R_STROBE :
               (prim.kind == P_WAIT) ? STS_WAIT :
               init_r ? IDLE : RESP;
   end
   assign cnt_load = (state == W_SETUP) || (go && (prim.kind == P_RD || prim.kind == P_WAIT));
   assign cnt_val  = (state == W_SETUP) ? CW'(T_WP - 1) :
                     (prim.kind == P_RD) ? CW'(T_ACC - 1) : CW'(T_TMO - 1);
   flash_wait_counter #(.W(CW)) u_wait (
      .CLK_50MHZ (CLK_50MHZ),
      .RST       (RST),
      .load      (cnt_load),
      .load_val  (cnt_val),
      .done      (cnt_done)
   );
   // Pin outputs are registered from the next state so they change on the same edge as the FSM.
   always_ff @(posedge CLK_50MHZ) begin
      if (RST) begin
         state     <= INIT;
         step_r    <= '0;
         init_r    <= 1'b1;
         cmd_r     <= OP_READ;
         addr_r    <= '0;
         wd_r      <= '0;
         data_r    <= '0;
         err_r     <= 1'b0;
         sts_q1    <= 1'b0;
         sts_q2    <= 1'b0;
         NF_A      <= '0;
         NF_D_O    <= '0;
         NF_D_OE   <= 1'b0;
         NF_CE     <= 1'b1;
         NF_OE     <= 1'b1;
         NF_WE     <= 1'b1;
         op_ready  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state  <= nxt;
         sts_q1 <= NF_STS;
         sts_q2 <= sts_q1;
         if (accept) begin
            cmd_r  <= op_cmd_e'(op_cmd);
            addr_r <= op_addr;
            wd_r   <= op_wdata;
            err_r  <= 1'b0;
         end
         if (go) step_r <= idx + 3'd1;
         if (go && prim.kind == P_WR) NF_D_O <= prim.use_wd ? sel_wd : DATA_W'(prim.cb);
         if (go && prim.kind == P_END) init_r <= 1'b0;
         if (state == R_STROBE && cnt_done) begin
            data_r <= NF_D_I;
            err_r  <= (cmd_r == OP_PROG || cmd_r == OP_ERASE) &&
                      |{NF_D_I[SR_ES], NF_D_I[SR_PS], NF_D_I[SR_VPPS], NF_D_I[SR_BLS]};
         end
         if (tmo) begin
            err_r  <= 1'b1;
            data_r <= '0;
         end
         NF_A      <= accept ? op_addr : addr_r;
         NF_CE     <= !(nxt inside {W_SETUP, W_STROBE, W_HOLD, R_STROBE});
         NF_OE     <= (nxt != R_STROBE);
         NF_WE     <= (nxt != W_STROBE);
         NF_D_OE   <= (nxt inside {W_SETUP, W_STROBE, W_HOLD});
         op_ready  <= (nxt == IDLE);
         rsp_valid <= (nxt == RESP);
         if (nxt == RESP) begin
            rsp_rdata <= data_r;
            rsp_err   <= err_r;
         end
      end
   end
endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: directed bench for flash_ctrl with a small flash model (8-bit and 16-bit builds)
module tb_flash_ctrl;
   import flash_pkg::*;
   localparam int RD_MARK = 256;
   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid, op_ready, rsp_valid, rsp_err;
   logic [1:0]  op_cmd;
   logic [23:0] op_addr, nf_a;
   logic [7:0]  op_wdata, rsp_rdata, nf_d_o, nf_d_i;
   logic        nf_d_oe, nf_ce, nf_oe, nf_we, nf_rp, nf_byte, nf_wp, nf_sts;
   logic        op_valid_w, op_ready_w, rsp_valid_w, rsp_err_w;
   logic [1:0]  op_cmd_w;
   logic [23:0] op_addr_w, nf_a_w;
   logic [15:0] op_wdata_w, rsp_rdata_w, nf_d_o_w, nf_d_i_w;
   logic        nf_d_oe_w, nf_ce_w, nf_oe_w, nf_we_w, nf_rp_w, nf_byte_w, nf_wp_w;
   logic [7:0]  sr, arr;
   logic        sr_mode = 1'b0;
   logic        we_p = 1'b1, oe_p = 1'b1;
   int          wlog[$];
   int          viol = 0;
   int          n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   flash_ctrl #(.ADDR_W(24), .DATA_W(8), .T_ACC(6), .T_WP(4), .T_TMO(100)) u_dut8 (
      .CLK_50MHZ(clk), .RST(rst), .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
      .op_addr(op_addr), .op_wdata(op_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .NF_A(nf_a), .NF_D_O(nf_d_o), .NF_D_OE(nf_d_oe), .NF_D_I(nf_d_i),
      .NF_CE(nf_ce), .NF_OE(nf_oe), .NF_WE(nf_we), .NF_RP(nf_rp), .NF_BYTE(nf_byte),
      .NF_WP(nf_wp), .NF_STS(nf_sts));
   flash_ctrl #(.ADDR_W(24), .DATA_W(16), .T_ACC(3), .T_WP(2), .T_TMO(100)) u_dut16 (
      .CLK_50MHZ(clk), .RST(rst), .op_valid(op_valid_w), .op_ready(op_ready_w), .op_cmd(op_cmd_w),
      .op_addr(op_addr_w), .op_wdata(op_wdata_w), .rsp_valid(rsp_valid_w), .rsp_rdata(rsp_rdata_w),
      .rsp_err(rsp_err_w), .NF_A(nf_a_w), .NF_D_O(nf_d_o_w), .NF_D_OE(nf_d_oe_w), .NF_D_I(nf_d_i_w),
      .NF_CE(nf_ce_w), .NF_OE(nf_oe_w), .NF_WE(nf_we_w), .NF_RP(nf_rp_w), .NF_BYTE(nf_byte_w),
      .NF_WP(nf_wp_w), .NF_STS(1'b1));
   assign nf_d_i   = !nf_oe ? (sr_mode ? sr : arr) : 8'h00;
   assign nf_d_i_w = !nf_oe_w ? 16'hBEEF : 16'h0000;
   // Flash model: logs completed writes (WE rising) and reads (OE rising), tracks read mode.
   always @(negedge clk) begin
      if (!we_p && nf_we) begin
         wlog.push_back(int'(nf_d_o));
         if (nf_d_o == 8'h70) sr_mode = 1'b1;
         else if (nf_d_o == 8'hFF) sr_mode = 1'b0;
      end
      if (!oe_p && nf_oe) wlog.push_back(RD_MARK);
      we_p = nf_we;
      oe_p = nf_oe;
      if ((nf_d_oe && !nf_oe) || (!nf_we && nf_ce) || (nf_d_oe_w && !nf_oe_w) || (!nf_we_w && nf_ce_w))
         viol++;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_log(input string tag, input int exp[$]);
      chk({tag, "_len"}, wlog.size(), exp.size());
      for (int i = 0; i < exp.size() && i < wlog.size(); i++) chk(tag, wlog[i], exp[i]);
   endtask
   task automatic op8(input logic [1:0] c, input logic [23:0] a, input logic [7:0] wd,
                      output logic [7:0] rd, output logic er, output int lat, output int oe_lo,
                      output logic [23:0] a_seen);
      int t = 0;
      while (!op_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("ready", op_ready, 1);
      wlog.delete();
      op_valid = 1'b1;
      op_cmd   = c;
      op_addr  = a;
      op_wdata = wd;
      lat = 0;
      oe_lo = 0;
      a_seen = '1;
      do begin
         @(negedge clk);
         op_valid = 1'b0;
         op_cmd   = ~c;
         op_addr  = ~a;
         op_wdata = ~wd;
         lat++;
         if (!nf_oe) oe_lo++;
         if (!nf_ce && a_seen == '1) a_seen = nf_a;
      end while (!rsp_valid && lat < 2000);
      chk("rsp_seen", rsp_valid, 1);
      rd = rsp_rdata;
      er = rsp_err;
      @(negedge clk);
      chk("rsp_pulse", rsp_valid, 0);
      chk("ready_back", op_ready, 1);
   endtask
   initial begin
      logic [7:0]  rd;
      logic        er;
      logic [23:0] as;
      int          lat, oe, t, rv;
      int          e[$];
      rst = 1'b1;
      op_valid = 1'b0; op_cmd = 2'd0; op_addr = '0; op_wdata = '0;
      op_valid_w = 1'b0; op_cmd_w = 2'd0; op_addr_w = '0; op_wdata_w = '0;
      nf_sts = 1'b1;
      sr = 8'h00;
      arr = 8'hA5;
      repeat (3) @(negedge clk);
      chk("rst_ce", nf_ce, 1);
      chk("rst_oe", nf_oe, 1);
      chk("rst_we", nf_we, 1);
      chk("rst_doe", nf_d_oe, 0);
      chk("rst_ready", op_ready, 0);
      chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
      chk("rst_a_d", {nf_a, nf_d_o}, 0);
      chk("rst_rp_wp_byte", {nf_rp, nf_wp, nf_byte}, 3'b100);
      chk("rst_byte16", nf_byte_w, 1);
      wlog.delete();
      rst = 1'b0;
      @(negedge clk);
      chk("init_ready_low", op_ready, 0);
      t = 0;
      while (!op_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("init_ready", op_ready, 1);
      e = '{'hFF};
      chk_log("init_seq", e);
      op8(OP_READ, 24'h000123, 8'h00, rd, er, lat, oe, as);
      chk("rd_data", rd, 8'hA5);
      chk("rd_err", er, 0);
      chk("rd_lat", lat, 8);
      chk("rd_oe_cycles", oe, 6);
      chk("rd_addr", as, 24'h000123);
      e = '{RD_MARK};
      chk_log("rd_seq", e);
      sr = 8'(1 << SR_WSMS);
      nf_sts = 1'b0;
      fork
         op8(OP_PROG, 24'h000010, 8'h3C, rd, er, lat, oe, as);
         begin
            repeat (50) @(posedge clk);
            nf_sts = 1'b1;
         end
      join
      chk("prog_data", rd, 8'h80);
      chk("prog_err", er, 0);
      chk("prog_waited", lat > 55, 1);
      chk("prog_addr", as, 24'h000010);
      e = '{'h40, 'h3C, 'h70, RD_MARK, 'h50, 'hFF};
      chk_log("prog_seq", e);
      sr = 8'hA0;
      op8(OP_ERASE, 24'h002000, 8'h00, rd, er, lat, oe, as);
      chk("erase_data", rd, 8'hA0);
      chk("erase_err", er, 1);
      e = '{'h20, 'hD0, 'h70, RD_MARK, 'h50, 'hFF};
      chk_log("erase_seq", e);
      sr = 8'h80;
      nf_sts = 1'b0;
      op8(OP_PROG, 24'h000044, 8'h11, rd, er, lat, oe, as);
      chk("tmo_data", rd, 8'h00);
      chk("tmo_err", er, 1);
      chk("tmo_lat", lat, 122);
      e = '{'h40, 'h11, 'hFF};
      chk_log("tmo_seq", e);
      nf_sts = 1'b1;
      sr = 8'h82;
      op8(OP_STATUS, 24'h000300, 8'h00, rd, er, lat, oe, as);
      chk("stat_data", rd, 8'h82);
      chk("stat_err", er, 0);
      e = '{'h70, RD_MARK, 'hFF};
      chk_log("stat_seq", e);
      op_valid = 1'b1;
      op_cmd   = OP_ERASE;
      op_addr  = 24'h000055;
      @(negedge clk);
      op_valid = 1'b0;
      t = 0;
      while (nf_we && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("mid_we_low", nf_we, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_ce", nf_ce, 1);
      chk("mid_we", nf_we, 1);
      chk("mid_doe", nf_d_oe, 0);
      chk("mid_ready", op_ready, 0);
      @(negedge clk);
      wlog.delete();
      t = 0;
      rv = 0;
      while (!op_ready && t < 200) begin
         @(negedge clk);
         t++;
         if (rsp_valid) rv++;
      end
      chk("mid_no_rsp", rv, 0);
      chk("mid_ready_back", op_ready, 1);
      e = '{'hFF};
      chk_log("mid_init_seq", e);
      chk("w_ready", op_ready_w, 1);
      op_valid_w = 1'b1;
      op_cmd_w   = OP_READ;
      op_addr_w  = 24'h000077;
      lat = 0;
      do begin
         @(negedge clk);
         op_valid_w = 1'b0;
         lat++;
      end while (!rsp_valid_w && lat < 200);
      chk("w_data", rsp_rdata_w, 16'hBEEF);
      chk("w_err", rsp_err_w, 0);
      chk("w_lat", lat, 5);
      chk("w_byte", nf_byte_w, 1);
      chk("invariants", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
